sc_mult_sequencer: RTL and testbench

Sequencer for the stochastic multiplication datapath. It accepts two unsigned binary operands over a valid/ready handshake and generates one stochastic bitstream per operand. It ANDs the two streams bit by bit, which is the stochastic multiply, over a full stream period, then counts the ones to return the binary product estimate. It sits between binary-domain producers and consumers and the bit-serial stochastic multiplier, and owns stream generation, length bookkeeping and result conversion.

---
 rtl/sc_mult_sequencer_pkg.sv | 24 ++
 rtl/sc_mult_sequencer_if.sv | 17 +
 rtl/sc_mult_sequencer_lfsr.sv | 17 +
 rtl/sc_mult_sequencer.sv | 82 ++++++++
 tb/tb_sc_mult_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/sc_mult_sequencer_pkg.sv
// sc_pkg: shared types and constants for the stochastic multiply sequencer.
package sc_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int SEED = 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    // Fibonacci feedback taps (bit n-1 for tap n), maximal length for each width
    function automatic logic [15:0] tap_mask(input int w);
        case (w)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            default: return 16'hD008;
        endcase
    endfunction
endpackage

// File: rtl/sc_mult_sequencer_if.sv
// sc_mult_sequencer_if: operand/result handshake bundle; stream taps exist only with SC_SEQ_STREAM_OUT_EN.
interface sc_mult_sequencer_if #(parameter int WIDTH = sc_pkg::DEF_WIDTH);
    logic in_valid, in_ready, abort, busy, out_valid, out_ready;
    logic [WIDTH-1:0] a_val, b_val, result, stream_len;
`ifdef SC_SEQ_STREAM_OUT_EN
    logic a_bit, b_bit, c_bit;
    modport master(output in_valid, a_val, b_val, abort, out_ready,
                   input in_ready, busy, out_valid, result, stream_len, a_bit, b_bit, c_bit);
    modport slave(input in_valid, a_val, b_val, abort, out_ready,
                  output in_ready, busy, out_valid, result, stream_len, a_bit, b_bit, c_bit);
`else
    modport master(output in_valid, a_val, b_val, abort, out_ready,
                   input in_ready, busy, out_valid, result, stream_len);
    modport slave(input in_valid, a_val, b_val, abort, out_ready,
                  output in_ready, busy, out_valid, result, stream_len);
`endif
endinterface

// File: rtl/sc_mult_sequencer_lfsr.sv
// sc_lfsr: maximal-length Fibonacci LFSR, reloads the seed on load and steps on enable.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             enable,
    output logic [WIDTH-1:0] value
);
    localparam logic [WIDTH-1:0] MASK = WIDTH'(tap_mask(WIDTH));
    always_ff @(posedge clk)
        if (!rst_n || load) value <= WIDTH'(SEED);
        else if (enable) value <= {value[WIDTH-2:0], ^(value & MASK)};
endmodule

// File: rtl/sc_mult_sequencer.sv
// sc_mult_sequencer: binary-in/binary-out stochastic multiplier sequencer over one L=2^WIDTH-1 stream period.
// Defining SC_SEQ_STREAM_OUT_EN exposes the a/b/c stream bits on the interface.
module sc_mult_sequencer
    import sc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic                clk,
    input logic                rst_n,
    sc_mult_sequencer_if.slave bus
);
    localparam logic [WIDTH-1:0] L = '1;
    state_t state;
    logic [WIDTH-1:0] a_q, b_q, cnt, acc, lfsr;
    logic run, accept, a_s, b_s, c_s, last;
    assign run = state == RUN;
    assign accept = bus.in_valid & bus.in_ready;
    assign a_s = run & (lfsr <= a_q);
    assign b_s = run & (cnt <= b_q);
    assign c_s = a_s & b_s;
    assign last = cnt == L;
    assign bus.stream_len = L;
`ifdef SC_SEQ_STREAM_OUT_EN
    assign bus.a_bit = a_s;
    assign bus.b_bit = b_s;
    assign bus.c_bit = c_s;
`endif
    sc_lfsr #(.WIDTH(WIDTH)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .enable(run),
        .value (lfsr)
    );
    // abort outranks out_ready, so a result seen together with abort is never handed over
    always_ff @(posedge clk)
        if (!rst_n) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            a_q           <= '0;
            b_q           <= '0;
            cnt           <= '0;
            acc           <= '0;
        end else if (state != IDLE && bus.abort) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
        end else case (state)
            IDLE: begin
                bus.in_ready <= !accept;
                bus.busy     <= accept;
                if (accept) begin
                    state <= RUN;
                    a_q   <= bus.a_val;
                    b_q   <= bus.b_val;
                    cnt   <= WIDTH'(1);
                    acc   <= '0;
                end
            end
            RUN: begin
                acc <= acc + WIDTH'(c_s);
                cnt <= cnt + WIDTH'(1);
                if (last) begin
                    state         <= DONE;
                    bus.out_valid <= 1'b1;
                    bus.result    <= acc + WIDTH'(c_s);
                end
            end
            DONE:
                if (bus.out_ready) begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                    bus.in_ready  <= 1'b1;
                end
            default: state <= IDLE;
        endcase
endmodule

// File: tb/tb_sc_mult_sequencer.sv
// tb_sc_mult_sequencer: directed vector table plus abort/reset/hold sequences for sc_mult_sequencer.
module tb_sc_mult_sequencer;
    import sc_pkg::*;
    localparam int W = 8;
    localparam int L = 255;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    sc_mult_sequencer_if #(.WIDTH(W)) bus ();
    sc_mult_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        int a;
        int b;
        int exp;
    } vec_t;
    vec_t vecs[8];
    int res_log[8];
`ifdef SC_SEQ_STREAM_OUT_EN
    int acnt, bcnt, ccnt;
`endif
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    // reference: x^8+x^6+x^5+x^4+1 Fibonacci stream against a 1..L ramp
    function automatic int model(input int a, input int b);
        logic [W-1:0] s;
        int acc;
        s = 1;
        acc = 0;
        for (int i = 1; i <= L; i++) begin
            if (int'(s) <= a && i <= b) acc++;
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
        return acc;
    endfunction
    task automatic start(input int a, input int b);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", bus.in_ready, 1);
        bus.a_val = W'(a);
        bus.b_val = W'(b);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask
    task automatic wait_done(input bit noise, output int n);
        n = 0;
`ifdef SC_SEQ_STREAM_OUT_EN
        acnt = 0;
        bcnt = 0;
        ccnt = 0;
`endif
        while (!bus.out_valid && n < 2 * L) begin
`ifdef SC_SEQ_STREAM_OUT_EN
            acnt += int'(bus.a_bit);
            bcnt += int'(bus.b_bit);
            ccnt += int'(bus.c_bit);
`endif
            if (noise) begin
                bus.in_valid = 1'b1;
                bus.a_val = W'(n);
                bus.b_val = ~W'(n);
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
    endtask
    task automatic finish_job();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("out_valid_after_hs", bus.out_valid, 0);
        check("in_ready_after_hs", bus.in_ready, 1);
        check("busy_after_hs", bus.busy, 0);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        int n, r;
        bit stable, seen;
        bus.in_valid = 1'b0;
        bus.a_val = '0;
        bus.b_val = '0;
        bus.abort = 1'b0;
        bus.out_ready = 1'b0;
        vecs[0] = '{255, 100, 100};
        vecs[1] = '{0, 255, 0};
        vecs[2] = '{255, 255, 255};
        vecs[3] = '{128, 128, model(128, 128)};
        vecs[4] = '{255, 7, 7};
        vecs[5] = '{100, 255, 100};
        vecs[6] = '{255, 0, 0};
        vecs[7] = '{0, 0, 0};
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", int'(bus.result), 0);
        check("rst_stream_len", int'(bus.stream_len), L);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check("idle_abort_in_ready", bus.in_ready, 1);
        check("idle_abort_busy", bus.busy, 0);
        for (int i = 0; i < 8; i++) begin
            start(vecs[i].a, vecs[i].b);
            check($sformatf("busy_run[%0d]", i), bus.busy, 1);
            check($sformatf("in_ready_run[%0d]", i), bus.in_ready, 0);
            wait_done(i == 0, n);
            check($sformatf("latency[%0d]", i), n, L);
            check($sformatf("result[%0d]", i), int'(bus.result), vecs[i].exp);
            check($sformatf("stream_len[%0d]", i), int'(bus.stream_len), L);
`ifdef SC_SEQ_STREAM_OUT_EN
            check($sformatf("a_ones[%0d]", i), acnt, vecs[i].a);
            check($sformatf("b_ones[%0d]", i), bcnt, vecs[i].b);
            check($sformatf("c_ones[%0d]", i), ccnt, vecs[i].exp);
`endif
            res_log[i] = int'(bus.result);
            finish_job();
        end
        check("result_128_range", int'(res_log[3] >= 56 && res_log[3] <= 72), 1);
        start(255, 100);
        wait_done(1'b0, n);
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.in_valid = 1'b1;
            bus.a_val = W'(3 + k);
            bus.b_val = W'(3);
            @(posedge clk);
            #1;
            if (int'(bus.result) != 100 || !bus.out_valid || bus.in_ready) stable = 1'b0;
        end
        bus.in_valid = 1'b0;
        check("hold_stable", int'(stable), 1);
        check("hold_result", int'(bus.result), 100);
        finish_job();
        start(200, 200);
        repeat (49) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_in_ready", bus.in_ready, 1);
        seen = 1'b0;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("abort_no_result", int'(seen), 0);
        start(255, 7);
        wait_done(1'b0, n);
        check("post_abort_result", int'(bus.result), 7);
        finish_job();
        start(255, 255);
        repeat (99) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrun_rst_in_ready", bus.in_ready, 0);
        check("midrun_rst_busy", bus.busy, 0);
        check("midrun_rst_out_valid", bus.out_valid, 0);
        check("midrun_rst_result", int'(bus.result), 0);
        check("midrun_rst_stream_len", int'(bus.stream_len), L);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_release_in_ready", bus.in_ready, 1);
        check("midrun_release_busy", bus.busy, 0);
        start(255, 50);
        wait_done(1'b0, n);
        check("abort_done_result", int'(bus.result), 50);
        bus.abort = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        bus.out_ready = 1'b0;
        check("abort_hs_out_valid", bus.out_valid, 0);
        check("abort_hs_busy", bus.busy, 0);
        check("abort_hs_in_ready", bus.in_ready, 1);
        start(10, 255);
        wait_done(1'b0, n);
        check("final_latency", n, L);
        check("final_result", int'(bus.result), 10);
        finish_job();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
